inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//   Boot loader that writes the instruction memory. The core only ever reads that memory.
//   Receives a byte stream over a valid/ready handshake and packs bytes into big-endian 32-bit words.
//   Writes each word to the instruction-memory write port.
//   Holds the core in reset (cpu_rst) until a complete, checksum-verified image is loaded.
// PARAMETERS
//   INST_MEM_DEPTH  256  instruction memory size in bytes; MAX_WORDS = INST_MEM_DEPTH/4
//   width           8    memory byte width; in_data width, word = 4*width bits
// PORTS
//   clk           in   1        clock, rising edge
//   rst           in   1        asynchronous reset, active-high
//   in_data       in   width    stream byte
//   in_valid      in   1        in_data valid
//   in_ready      out  1        loader can accept a byte; transfer = in_valid & in_ready
//   start         in   1        one-cycle pulse: restart load; honoured only in DONE or ERROR
//   mem_we        out  1        instruction-memory write enable, one-cycle pulse per word
//   mem_addr      out  32       byte address of write, word-aligned (index*4)
//   mem_wdata     out  4*width  word to write
//   cpu_rst       out  1        core reset; high in every state except DONE
//   done          out  1        image loaded and checksum matched
//   error         out  1        count > MAX_WORDS or checksum mismatch
//   words_loaded  out  16       number of words written so far
// BEHAVIOUR
//   Reset (async, rst=1): state=CNT_HI; outputs mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0.
//     Also cpu_rst=1, done=0, error=0, in_ready=0; in_ready rises the first clk after rst falls.
//   Stream format: CNT_HI, CNT_LO (16-bit word count N), then 4*N data bytes MSB-first, then 1 checksum byte.
//     The checksum is the XOR of all 4*N data bytes.
//   FSM: CNT_HI -> CNT_LO -> DATA -> CHK -> DONE | ERROR; every transition happens on an accepted byte.
//   CNT_LO accept:
//     N==0 -> CHK, expected checksum 0x00.
//     N>MAX_WORDS -> ERROR.
//     Otherwise -> DATA.
//   DATA: 2-bit byte counter and 4*width shift register; running XOR is updated on every data byte.
//     Accepting the 4th byte of a word loads mem_wdata/mem_addr; mem_we=1 exactly the next cycle.
//     words_loaded increments in that same cycle.
//     in_ready stays high during the write cycle; no stall, one byte per cycle sustained.
//     After the Nth word's 4th byte -> CHK.
//   CHK accept: byte==running XOR -> DONE, else -> ERROR.
//   DONE: cpu_rst=0, done=1, in_ready=0. Entered the cycle after the checksum byte is accepted.
//     It is always at least one cycle after the final mem_we.
//   ERROR: cpu_rst=1, error=1, in_ready=0. Memory contents already written are left as-is.
//   start in DONE/ERROR -> next cycle CNT_HI with:
//     cpu_rst=1, done=0, error=0, words_loaded=0, XOR=0, byte counter=0.
//   start in any other state is ignored. start coinciding with in_valid in DONE is ignored for data:
//     in_ready=0, so the byte is not taken.
//   in_valid low mid-word: the partial word is held indefinitely, with no timeout.
//   Address wraps never: N<=MAX_WORDS, so the highest address is 4*(MAX_WORDS-1).
//   rst asserted mid-load: the load is abandoned immediately; the next stream must restart at CNT_HI.
//   mem_we is registered; mem_addr/mem_wdata are stable while mem_we=1 and hold their last value otherwise.
// TESTING
//   Stream 00 01 20 08 00 05 2D: N=1, word 0x20080005, XOR 0x2D.
//     -> one mem_we, addr 0, data 0x20080005; done=1 and cpu_rst=0 the cycle after the 0x2D accept.
//   N=3 streamed back-to-back with in_valid held high and a correct checksum.
//     -> mem_we at addr 0, 4, 8; words_loaded=3; in_ready never drops before DONE.
//   N=0x0041 (65 > 64).
//     -> ERROR after CNT_LO accept; no mem_we; cpu_rst stays 1.
//   N=1, correct data, checksum 0x2C instead of 0x2D.
//     -> error=1, done=0, cpu_rst=1; the word is still written at addr 0.
//   Random in_valid gaps within a 2-word image.
//     -> same mem writes and data as the gap-free case; in DONE, pulse start, then reload N=1.
//     -> cpu_rst returns to 1 next cycle; the new word is written to addr 0.
//   rst asserted after 2 data bytes of a word.
//     -> all outputs at reset values asynchronously; no mem_we for the partial word.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Boot loader: unpacks a counted, XOR-checksummed byte stream into big-endian words
// for the instruction memory and keeps the core in reset until the image is verified.
module inst_mem_loader #(
    parameter int INST_MEM_DEPTH = 256,
    parameter int width          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [width-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               start,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [4*width-1:0] mem_wdata,
    output logic               cpu_rst,
    output logic               done,
    output logic               error,
    output logic [15:0]        words_loaded
);
    localparam int MAX_WORDS = INST_MEM_DEPTH / 4;

    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA, S_CHK, S_DONE, S_ERROR
    } state_t;

    state_t             state, state_nxt;
    logic               armed;
    logic [width-1:0]   cnt_hi;
    logic [width-1:0]   xsum;
    logic [15:0]        n_words;
    logic [15:0]        n_cnt;
    logic [1:0]         bcnt;
    logic [3*width-1:0] shreg;
    logic               take;
    logic               restart;

    // The count is always two stream bytes, high byte first.
    assign n_cnt   = 16'({cnt_hi, in_data});
    assign take    = in_valid && in_ready;
    assign restart = start && (state == S_DONE || state == S_ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_CNT_HI;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = armed && (state == S_CNT_HI || state == S_CNT_LO ||
                              state == S_DATA   || state == S_CHK);
        cpu_rst   = (state != S_DONE);
        done      = (state == S_DONE);
        error     = (state == S_ERROR);
        case (state)
            S_CNT_HI: if (take) state_nxt = S_CNT_LO;
            S_CNT_LO: if (take) begin
                if (n_cnt == 16'd0)                   state_nxt = S_CHK;
                else if (n_cnt > 16'(MAX_WORDS))      state_nxt = S_ERROR;
                else                                  state_nxt = S_DATA;
            end
            S_DATA: if (take && bcnt == 2'd3 && (words_loaded + 16'd1) == n_words)
                state_nxt = S_CHK;
            S_CHK: if (take) state_nxt = (in_data == xsum) ? S_DONE : S_ERROR;
            S_DONE, S_ERROR: if (start) state_nxt = S_CNT_HI;
            default: state_nxt = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed        <= 1'b0;
            cnt_hi       <= '0;
            xsum         <= '0;
            n_words      <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            armed  <= 1'b1;
            mem_we <= 1'b0;
            if (restart) begin
                words_loaded <= '0;
                xsum         <= '0;
                bcnt         <= '0;
            end
            if (take) begin
                case (state)
                    S_CNT_HI: cnt_hi <= in_data;
                    S_CNT_LO: n_words <= n_cnt;
                    S_DATA: begin
                        shreg <= {shreg[2*width-1:0], in_data};
                        xsum  <= xsum ^ in_data;
                        bcnt  <= bcnt + 2'd1;
                        // Fourth byte completes the word; write lands next cycle.
                        if (bcnt == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_wdata    <= {shreg, in_data};
                            mem_addr     <= 32'({words_loaded, 2'b00});
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed + randomized bench for inst_mem_loader; expected writes and outcome come
// from an image-level model (word list, XOR of bytes, count limit).
module tb_inst_mem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        start = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst, done, error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] img[$];
    logic [63:0] got[$];

    inst_mem_loader #(.INST_MEM_DEPTH(256), .width(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: mem_we is a single-cycle pulse, so one record per write.
    always @(negedge clk) if (mem_we) got.push_back({mem_addr, mem_wdata});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte after `gap` idle cycles; returns at posedge+1 after acceptance.
    task automatic send(input logic [7:0] b, input int gap, inout int stalls);
        int  tmo;
        logic ok;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        tmo = 0;
        forever begin
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
            stalls++;
            tmo++;
            if (tmo > 50) begin
                chk("accept_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic mk_img(input int n);
        img.delete();
        repeat (n) img.push_back($urandom);
    endtask

    // Streams the image in `img` with word count n; delta corrupts the checksum byte.
    task automatic load(input logic [15:0] n, input logic [7:0] delta, input int gap,
                        output int stalls);
        logic [7:0] x;
        logic [7:0] b;
        bit         ok;
        x = 8'h00;
        stalls = 0;
        got.delete();
        send(n[15:8], gap, stalls);
        send(n[7:0], gap, stalls);
        if (n > 16'd64) begin
            in_valid = 1'b0;
            chk("cnt_over_error", error, 1);
            chk("cnt_over_cpu_rst", cpu_rst, 1);
            chk("cnt_over_ready", in_ready, 0);
            repeat (3) begin @(posedge clk); #1; end
            chk("cnt_over_no_we", got.size(), 0);
            return;
        end
        foreach (img[i]) begin
            for (int k = 3; k >= 0; k--) begin
                b = img[i][8*k +: 8];
                x ^= b;
                send(b, (gap > 0) ? $urandom_range(0, gap) : 0, stalls);
            end
        end
        chk("pre_chk_not_done", done, 0);
        send(x ^ delta, gap, stalls);
        in_valid = 1'b0;
        ok = (delta == 8'h00);
        chk("end_done", done, ok);
        chk("end_error", error, !ok);
        chk("end_cpu_rst", cpu_rst, !ok);
        chk("end_ready", in_ready, 0);
        chk("end_words", words_loaded, n);
        chk("end_nwrites", got.size(), n);
        foreach (got[i]) if (i < img.size())
            chk($sformatf("write%0d", i), got[i], {32'(i * 4), img[i]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_cpu_rst", cpu_rst, 1);
        chk("start_done", done, 0);
        chk("start_error", error, 0);
        chk("start_words", words_loaded, 0);
        chk("start_ready", in_ready, 1);
    endtask

    initial begin
        int st;
        int n;
        logic [7:0] d;
        // Reset values
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk("ready_low_after_rst", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_rises", in_ready, 1);

        // Single-word image from the reference stream
        img.delete(); img.push_back(32'h20080005);
        load(16'd1, 8'h00, 0, st);

        // Start coincident with a valid byte in DONE: byte must not be taken
        in_valid = 1'b1; in_data = 8'hAA;
        pulse_start();
        in_valid = 1'b0;

        // Three words, back-to-back, no stall allowed
        mk_img(3);
        load(16'd3, 8'h00, 0, st);
        chk("n3_no_stall", st, 0);
        pulse_start();

        // Oversized count
        img.delete();
        load(16'h0041, 8'h00, 0, st);
        pulse_start();

        // Bad checksum (0x2C instead of 0x2D); word still written
        img.delete(); img.push_back(32'h20080005);
        load(16'd1, 8'h01, 0, st);
        pulse_start();

        // Two words with random gaps, then reload N=1
        mk_img(2);
        load(16'd2, 8'h00, 3, st);
        pulse_start();
        mk_img(1);
        load(16'd1, 8'h00, 0, st);
        pulse_start();

        // Zero-length image and max-size image
        img.delete();
        load(16'd0, 8'h00, 0, st);
        pulse_start();
        mk_img(64);
        load(16'd64, 8'h00, 0, st);
        chk("max_last_addr", got[63][63:32], 32'd252);
        pulse_start();

        // Randomized images
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 5);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            mk_img(n);
            load(16'(n), d, $urandom_range(0, 2), st);
            pulse_start();
        end

        // Reset after two data bytes of a word
        got.delete();
        st = 0;
        send(8'h00, 0, st); send(8'h01, 0, st);
        send(8'h12, 0, st); send(8'h34, 0, st);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_cpu_rst", cpu_rst, 1);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_words", words_loaded, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk("midrst_we", mem_we, 0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_we", got.size(), 0);
        img.delete(); img.push_back(32'hCAFEF00D);
        load(16'd1, 8'h00, 1, st);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
